chave_detector: RTL and testbench

//  Sequential prober for the selectable AND/OR cell (inputs a, b, chave; output s).
//  - Drives all four (a,b) combinations into a cell under test and samples s.
//  - Decodes which function the cell's chave selected: AND (chave=1) or OR (chave=0).
//  - Flags fault when the sampled truth table matches neither function.
//  - Sits beside the cell in self-test benches and board-level checks.

---
 rtl/chave_detector.sv | 146 ++++++++++++++
 tb/tb_chave_detector.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/chave_detector.sv
// Sequential prober for a selectable AND/OR cell: sweeps all {a,b} inputs, samples s, decodes the select.
// Optional macro CHAVE_DET_RETRY_EN: a first sweep that decodes as fault is rerun once automatically.
module chave_detector #(
  parameter int SETTLE = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       s_in,
  output logic       a_out,
  output logic       b_out,
  output logic       busy,
  output logic       done,
  output logic       valid,
  output logic       chave_out,
  output logic       fault,
  output logic [3:0] pattern
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SWEEP  = 2'd1,
    DECIDE = 2'd2,
    RETRY  = 2'd3
  } state_t;

  state_t     state, state_next;
  logic [3:0] cnt, cnt_next;
  logic [1:0] combo, combo_next;
  logic [3:0] pattern_next;
  logic       busy_next, done_next, valid_next, chave_next, fault_next;
  logic       is_and, is_or, bad;
`ifdef CHAVE_DET_RETRY_EN
  logic       retried, retried_next;
`endif

  assign is_and = (pattern == 4'b1000);
  assign is_or  = (pattern == 4'b1110);
  assign bad    = !(is_and || is_or);

  // The cell sees the current combination only while sweeping; otherwise both inputs rest at 0.
  assign a_out = (state == SWEEP) & combo[1];
  assign b_out = (state == SWEEP) & combo[0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      combo     <= 2'd0;
      pattern   <= 4'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      valid     <= 1'b0;
      chave_out <= 1'b0;
      fault     <= 1'b0;
`ifdef CHAVE_DET_RETRY_EN
      retried   <= 1'b0;
`endif
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      combo     <= combo_next;
      pattern   <= pattern_next;
      busy      <= busy_next;
      done      <= done_next;
      valid     <= valid_next;
      chave_out <= chave_next;
      fault     <= fault_next;
`ifdef CHAVE_DET_RETRY_EN
      retried   <= retried_next;
`endif
    end
  end

  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    combo_next   = combo;
    pattern_next = pattern;
    busy_next    = busy;
    done_next    = 1'b0;
    valid_next   = valid;
    chave_next   = chave_out;
    fault_next   = fault;
`ifdef CHAVE_DET_RETRY_EN
    retried_next = retried;
`endif
    case (state)
      IDLE: begin
        if (start) begin
          state_next   = SWEEP;
          cnt_next     = 4'd0;
          combo_next   = 2'd0;
          pattern_next = 4'd0;
          busy_next    = 1'b1;
          valid_next   = 1'b0;
          chave_next   = 1'b0;
          fault_next   = 1'b0;
`ifdef CHAVE_DET_RETRY_EN
          retried_next = 1'b0;
`endif
        end
      end
      SWEEP: begin
        // Last edge of the settle window: capture s and advance to the next combination.
        if (cnt == 4'(SETTLE)) begin
          pattern_next[combo] = s_in;
          cnt_next            = 4'd0;
          combo_next          = combo + 2'd1;
          if (combo == 2'd3) state_next = DECIDE;
        end else begin
          cnt_next = cnt + 4'd1;
        end
      end
      DECIDE: begin
        state_next = IDLE;
        done_next  = 1'b1;
        valid_next = 1'b1;
        busy_next  = 1'b0;
        chave_next = is_and;
        fault_next = bad;
`ifdef CHAVE_DET_RETRY_EN
        if (bad && !retried) begin
          state_next   = RETRY;
          retried_next = 1'b1;
          done_next    = 1'b0;
          valid_next   = valid;
          busy_next    = 1'b1;
          chave_next   = chave_out;
          fault_next   = fault;
        end
`endif
      end
`ifdef CHAVE_DET_RETRY_EN
      RETRY: begin
        state_next   = SWEEP;
        cnt_next     = 4'd0;
        combo_next   = 2'd0;
        pattern_next = 4'd0;
      end
`endif
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_chave_detector.sv
// Randomized bench for chave_detector: two instances (SETTLE=1 and SETTLE=0) probe a shared cell truth table.
module tb_chave_detector;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] cell_tt;

  logic       s_i[2], a_o[2], b_o[2], busy_o[2], done_o[2], valid_o[2], chave_o[2], fault_o[2];
  logic [3:0] pat_o[2];

  int checks   = 0;
  int failures = 0;

`ifdef CHAVE_DET_RETRY_EN
  localparam bit RETRY_ON = 1'b1;
`else
  localparam bit RETRY_ON = 1'b0;
`endif

  always #5 clk = ~clk;

  chave_detector #(.SETTLE(1)) u_dut_s1 (
    .clk(clk), .reset(reset), .start(start), .s_in(s_i[0]),
    .a_out(a_o[0]), .b_out(b_o[0]), .busy(busy_o[0]), .done(done_o[0]),
    .valid(valid_o[0]), .chave_out(chave_o[0]), .fault(fault_o[0]), .pattern(pat_o[0])
  );

  chave_detector #(.SETTLE(0)) u_dut_s0 (
    .clk(clk), .reset(reset), .start(start), .s_in(s_i[1]),
    .a_out(a_o[1]), .b_out(b_o[1]), .busy(busy_o[1]), .done(done_o[1]),
    .valid(valid_o[1]), .chave_out(chave_o[1]), .fault(fault_o[1]), .pattern(pat_o[1])
  );

  // Cell under test: s is whatever its truth table says for the applied {a,b}.
  always_comb begin
    s_i[0] = cell_tt[{a_o[0], b_o[0]}];
    s_i[1] = cell_tt[{a_o[1], b_o[1]}];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int settle_of(input int i);
    return (i == 0) ? 1 : 0;
  endfunction

  function automatic logic [3:0] gate_tt(input bit use_and);
    logic [3:0] r;
    for (int a = 0; a < 2; a++)
      for (int b = 0; b < 2; b++)
        r[a*2+b] = use_and ? 1'(a * b) : 1'((a + b) > 0);
    return r;
  endfunction

  function automatic logic [10:0] outs(input int i);
    return {a_o[i], b_o[i], busy_o[i], done_o[i], valid_o[i], chave_o[i], fault_o[i], pat_o[i]};
  endfunction

  // Expected {a,b} seen each cycle from the start edge through the done cycle.
  task automatic make_trace(input int s, input bit is_fault, output int q[$]);
    int reps;
    q.delete();
    reps = (RETRY_ON && is_fault) ? 2 : 1;
    for (int r = 0; r < reps; r++) begin
      if (r > 0) q.push_back(0);
      for (int c = 0; c < 4; c++)
        for (int k = 0; k <= s; k++) q.push_back(c);
      q.push_back(0);
    end
    q.push_back(0);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic run_sweep(input logic [3:0] tt, input bit poke);
    int   trace[2][$];
    int   exp_q[$];
    int   lat[2], ndone[2], mism;
    bit   seen[2];
    logic exp_and, exp_fault;
    cell_tt = tt;
    exp_and   = (tt == gate_tt(1'b1));
    exp_fault = !exp_and && (tt != gate_tt(1'b0));
    for (int i = 0; i < 2; i++) begin
      lat[i] = -1; ndone[i] = 0; seen[i] = 1'b0; trace[i].delete();
    end
    pulse_start();
    for (int k = 0; k < 40; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      if (poke && k == 4) start = 1'b1;
      if (poke && k == 5) start = 1'b0;
      for (int i = 0; i < 2; i++) begin
        if (k == 0) begin
          check($sformatf("busy_at_start[%0d]", i), 32'(busy_o[i]), 32'd1);
          check($sformatf("valid_at_start[%0d]", i), 32'(valid_o[i]), 32'd0);
        end
        if (!seen[i]) trace[i].push_back(int'({a_o[i], b_o[i]}));
        if (done_o[i] === 1'b1) begin
          ndone[i]++;
          if (!seen[i]) begin
            seen[i] = 1'b1;
            lat[i]  = k;
          end
        end
      end
    end
    for (int i = 0; i < 2; i++) begin
      make_trace(settle_of(i), exp_fault, exp_q);
      mism = (trace[i].size() > exp_q.size()) ? trace[i].size() - exp_q.size()
                                              : exp_q.size() - trace[i].size();
      for (int j = 0; j < trace[i].size() && j < exp_q.size(); j++)
        if (trace[i][j] != exp_q[j]) mism++;
      check($sformatf("latency[%0d]", i), 32'(lat[i]), 32'(exp_q.size() - 1));
      check($sformatf("done_count[%0d]", i), 32'(ndone[i]), 32'd1);
      check($sformatf("ab_trace[%0d]", i), 32'(mism), 32'd0);
      check($sformatf("pattern[%0d]", i), 32'(pat_o[i]), 32'(tt));
      check($sformatf("chave_out[%0d]", i), 32'(chave_o[i]), 32'(exp_and));
      check($sformatf("fault[%0d]", i), 32'(fault_o[i]), 32'(exp_fault));
      check($sformatf("valid_end[%0d]", i), 32'(valid_o[i]), 32'd1);
      check($sformatf("busy_end[%0d]", i), 32'(busy_o[i]), 32'd0);
      $display("sweep inst=%0d settle=%0d tt=%b poke=%0d lat=%0d dones=%0d pattern=%b chave=%0b fault=%0b",
               i, settle_of(i), tt, poke, lat[i], ndone[i], pat_o[i], chave_o[i], fault_o[i]);
    end
  endtask

  task automatic mid_reset();
    cell_tt = gate_tt(1'b1);
    pulse_start();
    repeat (2) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    for (int i = 0; i < 2; i++)
      check($sformatf("mid_reset_outs[%0d]", i), 32'(outs(i)), 32'd0);
    $display("mid-sweep reset outs0=%h outs1=%h", outs(0), outs(1));
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    logic [3:0] tt;
    reset   = 1'b1;
    start   = 1'b0;
    cell_tt = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++)
      check($sformatf("reset_outs[%0d]", i), 32'(outs(i)), 32'd0);
    $display("reset outs0=%h outs1=%h", outs(0), outs(1));
    @(negedge clk);
    reset = 1'b0;

    run_sweep(gate_tt(1'b1), 1'b0);
    run_sweep(gate_tt(1'b0), 1'b0);
    run_sweep(4'b0000, 1'b0);
    run_sweep(gate_tt(1'b1), 1'b1);
    mid_reset();
    run_sweep(gate_tt(1'b1), 1'b0);
    for (int n = 0; n < 8; n++) begin
      case ($urandom_range(0, 2))
        0:       tt = gate_tt(1'b1);
        1:       tt = gate_tt(1'b0);
        default: tt = 4'($urandom_range(0, 15));
      endcase
      run_sweep(tt, 1'($urandom_range(0, 1)) & (tt == gate_tt(1'b1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
